// File: rtl/addsub_pkg.sv
// Shared constants for the adder-subtractor operand sequencer.
// State encodings, default width and settle-counter width.
package addsub_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/addsub_settle_timer.sv
// Loadable down-counter that flags when the settle dwell is over.
// done is high while running with the count at zero.
module addsub_settle_timer
    import addsub_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // reload on accept, otherwise count down to zero while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/addsub_op_sequencer.sv
// Registers operands for the external CLA adder, waits for it to settle,
// captures its result into a handshaked output and a running accumulator.
module addsub_op_sequencer
    import addsub_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_acc,
    input  logic             acc_clear,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_c,
    input  logic             add_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             res_vld;
    logic             accept;
    logic             capture;
    logic             done;

    assign acc_next = acc_clear ? '0 : acc;
    assign accept   = (state == ST_IDLE) && in_valid;
    assign capture  = (state == ST_SETTLE) && done;

    addsub_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(accept),
        .run (state == ST_SETTLE),
        .done(done)
    );

    // control FSM plus operand and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            res_vld    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a   <= in_acc ? acc_next : in_a;
                        op_b   <= in_b;
                        op_sub <= in_sub;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (done) begin
                        out_result <= add_c;
                        out_ovf    <= add_ovf;
                        res_vld    <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // accumulator: capture has priority over a clear on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (capture) begin
            acc <= add_c;
        end else if (acc_clear) begin
            acc <= '0;
        end
    end

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_HOLD);
    assign add_a     = op_a;
    assign add_b     = op_b;
    assign add_sub   = op_sub;
    assign out_zero  = res_vld && (out_result == '0);
    assign out_neg   = out_result[WIDTH-1];

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Bench for addsub_op_sequencer with a behavioural adder beside it.
// Vector table plus hand-written reset-abort sequence.
module tb_addsub_op_sequencer;

    localparam int W = 16;
    localparam int SC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_acc;
    logic         acc_clear;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_sub;
    logic [W-1:0] add_c;
    logic         add_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // behavioural stand-in for the CLA adder-subtractor
    always_comb begin
        add_c = add_sub ? (add_a - add_b) : (add_a + add_b);
        if (add_sub)
            add_ovf = (add_a[W-1] != add_b[W-1]) && (add_c[W-1] != add_a[W-1]);
        else
            add_ovf = (add_a[W-1] == add_b[W-1]) && (add_c[W-1] != add_a[W-1]);
    end

    addsub_op_sequencer #(
        .WIDTH(W),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_acc    (in_acc),
        .acc_clear (acc_clear),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sub   (add_sub),
        .add_c     (add_c),
        .add_ovf   (add_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         acc;
        logic         clr;
        int           hold;
        logic [W-1:0] r;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic         ovf;
    } exp_t;

    vec_t         tbl[8];
    exp_t         sb[$];
    logic [W-1:0] model_acc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        exp_t e;
        logic [W-1:0] ea;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_sub    = v.sub;
        in_acc    = v.acc;
        acc_clear = v.clr;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
        ea = v.acc ? (v.clr ? '0 : model_acc) : v.a;
        @(posedge clk);
        e.r = v.r;
        e.ovf = v.ovf;
        sb.push_back(e);
        model_acc = v.r;
        @(negedge clk);
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        in_a      = 16'h5A5A;
        n = 1;
        while (!out_valid && n < 20) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("settle_add_a", 32'(add_a), 32'(ea));
            @(negedge clk);
            n++;
        end
        chk("latency", n, SC + 1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_result", 32'(out_result), 32'(v.r));
            chk("hold_add_a", 32'(add_a), 32'(ea));
            chk("hold_add_b", 32'(add_b), 32'(v.b));
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("result", 32'(out_result), 32'(e.r));
            chk("ovf", 32'(out_ovf), 32'(e.ovf));
            chk("zero", 32'(out_zero), 32'(e.r == '0));
            chk("neg", 32'(out_neg), 32'(e.r[W-1]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        tbl[0] = '{16'hB5EA, 16'h250B, 1'b0, 1'b0, 1'b0, 0, 16'hDAF5, 1'b0};
        tbl[1] = '{16'h0100, 16'h015E, 1'b1, 1'b0, 1'b0, 0, 16'hFFA2, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 0, 16'hFFFE, 1'b1};
        tbl[3] = '{16'h1234, 16'h0064, 1'b0, 1'b1, 1'b1, 0, 16'h0064, 1'b0};
        tbl[4] = '{16'hABCD, 16'h0064, 1'b0, 1'b1, 1'b0, 0, 16'h00C8, 1'b0};
        tbl[5] = '{16'h0F0F, 16'h0064, 1'b0, 1'b1, 1'b0, 0, 16'h012C, 1'b0};
        tbl[6] = '{16'h7777, 16'h012C, 1'b1, 1'b1, 1'b0, 0, 16'h0000, 1'b0};
        tbl[7] = '{16'hB5EA, 16'hFFFA, 1'b1, 1'b0, 1'b0, 5, 16'hB5F0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        in_acc = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b0;
        model_acc = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_sub", 32'(add_sub), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", {29'd0, out_ovf, out_zero, out_neg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i]);
        end

        // abort an operation with reset during the settle dwell
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 16'd153;
        in_b = 16'hFF09;
        in_sub = 1'b0;
        in_acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_settle", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
            chk("abort_idle", 32'(in_ready), 32'd1);
        end
        run_op('{16'h4444, 16'h0007, 1'b0, 1'b1, 1'b0, 0, 16'h0007, 1'b0});
        run_op('{16'd153, 16'hFF09, 1'b0, 1'b0, 1'b0, 0, 16'hFFA2, 1'b0});

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
